// File: rtl/riscv_mc_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller:
// FSM states, ALU codes, opcodes, select encodings, legality check.
package riscv_mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRWB   = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ERROR    = 4'd15
  } state_e;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SHL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;
  localparam logic [3:0] ALU_SHA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_B    = 4'd10;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // Whole-instruction legality, resolved once in DECODE so an
  // illegal op never reaches a state that asserts an enable.
  function automatic logic instr_legal(input logic [31:0] ins);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       ok;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    ok = 1'b0;
    case (op)
      OP_R:
        ok = (f7 == 7'h00) ||
             (f7 == 7'h20 &&
              (f3 == 3'b000 || f3 == 3'b101));
      OP_I:
        if (f3 == 3'b001)
          ok = (f7 == 7'h00);
        else if (f3 == 3'b101)
          ok = (f7 == 7'h00) || (f7 == 7'h20);
        else
          ok = 1'b1;
      OP_LOAD:
        ok = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      OP_STORE:
        ok = !f3[2] && !(f3[1] && f3[0]);
      OP_BRANCH:
        ok = (f3[2:1] != 2'b01);
      OP_JALR:
        ok = (f3 == 3'b000);
      OP_JAL, OP_LUI, OP_AUIPC:
        ok = 1'b1;
      default:
        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_mc_controller_alu_decoder.sv
// ALU operation decoder: (state, opcode, funct3, funct7[5]) -> alu_control.
// Purely combinational; ADD unless the state needs something else.
module riscv_alu_decoder
  import riscv_mc_controller_pkg::*;
(
  input  state_e     state,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  logic is_r;
  assign is_r = (opcode == OP_R);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (state)
      S_EXECR, S_EXECI: begin
        unique case (funct3)
          3'b000: alu_control = (is_r && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SHL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7_5 ? ALU_SHA : ALU_SHR;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
      end
      S_BRANCH: begin
        case (funct3[2:1])
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_SUB;
        endcase
      end
      S_LUI:   alu_control = ALU_B;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control FSM driving datapath selects and enables.
// In: clk, rst_n, instr, zero. Out: enables, selects, alu_control, illegal, state, instret.
module riscv_mc_controller
  import riscv_mc_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       pc_write_c, mem_write_c;
  logic       ir_write_c, reg_write_c;
  logic       br_taken;
  logic       unused;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused = ^{instr[24:15], instr[11:7]};

  // funct3[0] inverts the sense; funct3[2] swaps eq/ne for lt/ge.
  assign br_taken = zero ^ funct3[0] ^ funct3[2];

  riscv_alu_decoder u_alu_dec (
    .state       (state_q),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7_5    (instr[30]),
    .alu_control (alu_control)
  );

  always_comb begin
    state_d     = state_q;
    pc_write_c  = 1'b0;
    adr_src     = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    unique case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = SRCB_4;
        result_src = RES_ALURES;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        if (!instr_legal(instr)) begin
          state_d = S_ERROR;
        end else begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = S_MEMADR;
            OP_R:              state_d = S_EXECR;
            OP_I:              state_d = S_EXECI;
            OP_BRANCH:         state_d = S_BRANCH;
            OP_JAL:            state_d = S_JAL;
            OP_JALR:           state_d = S_JALR;
            OP_LUI:            state_d = S_LUI;
            OP_AUIPC:          state_d = S_AUIPC;
            default:           state_d = S_ERROR;
          endcase
        end
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_RS2;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_RS2;
        pc_write_c = br_taken;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_4;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_write_c = 1'b1;
        state_d    = S_JALRWB;
      end
      S_JALRWB: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_4;
        result_src  = RES_ALURES;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_LUI: begin
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        state_d   = S_ALUWB;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_comb begin
    illegal_d = illegal_q | (state_d == S_ERROR);
    instret_d = instret_q;
    if (state_d == S_FETCH && state_q != S_FETCH)
      instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Reset lands in FETCH, whose enables must not fire while held.
  assign pc_write  = pc_write_c  & rst_n;
  assign mem_write = mem_write_c & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;
  assign illegal   = illegal_q;
  assign state     = state_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Bench for riscv_mc_controller: per-instruction expected cycle
// sequences from the ISA rules, checked on every cycle.
module tb_riscv_mc_controller;
  import riscv_mc_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [3:0]  alu_control, state;
  logic        illegal;
  logic [31:0] instret;

  riscv_mc_controller #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .illegal(illegal),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // pcw: 0/1 literal, 2 = conditional on branch outcome
  typedef struct {
    int st; int pcw; int adr; int mw; int irw;
    int rw; int rs; int sa; int sb; int alu;
  } rec_t;

  rec_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   instret_m = 0;

  function automatic rec_t mk(int st, int pcw, int adr, int mw,
                              int irw, int rw, int rs, int sa,
                              int sb, int alu);
    rec_t r;
    r.st = st; r.pcw = pcw; r.adr = adr; r.mw = mw; r.irw = irw;
    r.rw = rw; r.rs = rs; r.sa = sa; r.sb = sb; r.alu = alu;
    return r;
  endfunction

  function automatic bit legal_m(logic [31:0] ins);
    int op, f3, f7;
    op = int'(ins[6:0]); f3 = int'(ins[14:12]); f7 = int'(ins[31:25]);
    if (op == 7'h33) return f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5));
    if (op == 7'h13) begin
      if (f3 == 1) return f7 == 0;
      if (f3 == 5) return f7 == 0 || f7 == 32;
      return 1;
    end
    if (op == 7'h03) return !(f3 == 3 || f3 == 6 || f3 == 7);
    if (op == 7'h23) return f3 <= 2;
    if (op == 7'h63) return !(f3 == 2 || f3 == 3);
    if (op == 7'h67) return f3 == 0;
    if (op == 7'h6F || op == 7'h37 || op == 7'h17) return 1;
    return 0;
  endfunction

  function automatic int alu_arith(logic [31:0] ins, bit is_r);
    int f3;
    f3 = int'(ins[14:12]);
    if (f3 == 0) return (is_r && ins[30]) ? int'(ALU_SUB) : int'(ALU_ADD);
    if (f3 == 1) return int'(ALU_SHL);
    if (f3 == 2) return int'(ALU_SLT);
    if (f3 == 3) return int'(ALU_SLTU);
    if (f3 == 4) return int'(ALU_XOR);
    if (f3 == 5) return ins[30] ? int'(ALU_SHA) : int'(ALU_SHR);
    if (f3 == 6) return int'(ALU_OR);
    return int'(ALU_AND);
  endfunction

  function automatic int alu_branch(logic [31:0] ins);
    int f3;
    f3 = int'(ins[14:12]);
    if (f3 == 4 || f3 == 5) return int'(ALU_SLT);
    if (f3 == 6 || f3 == 7) return int'(ALU_SLTU);
    return int'(ALU_SUB);
  endfunction

  function automatic int taken_m(logic [31:0] ins, logic z);
    int f3;
    f3 = int'(ins[14:12]);
    if (f3 == 0 || f3 == 5 || f3 == 7) return int'(z);
    return int'(!z);
  endfunction

  task automatic build(input logic [31:0] ins, input int nerr);
    int op;
    int add;
    op = int'(ins[6:0]);
    add = int'(ALU_ADD);
    q.delete();
    q.push_back(mk(0, 1, 0, 0, 1, 0, 2, 0, 2, add));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, add));
    if (!legal_m(ins)) begin
      for (int i = 0; i < nerr; i++)
        q.push_back(mk(15, 0, 0, 0, 0, 0, 0, 0, 0, add));
    end else if (op == 7'h03) begin
      q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, add));
      q.push_back(mk(3, 0, 1, 0, 0, 0, 0, 0, 0, add));
      q.push_back(mk(4, 0, 0, 0, 0, 1, 1, 0, 0, add));
    end else if (op == 7'h23) begin
      q.push_back(mk(2, 0, 0, 0, 0, 0, 0, 2, 1, add));
      q.push_back(mk(5, 0, 1, 1, 0, 0, 0, 0, 0, add));
    end else if (op == 7'h33 || op == 7'h13) begin
      if (op == 7'h33)
        q.push_back(mk(6, 0, 0, 0, 0, 0, 0, 2, 0, alu_arith(ins, 1)));
      else
        q.push_back(mk(7, 0, 0, 0, 0, 0, 0, 2, 1, alu_arith(ins, 0)));
      q.push_back(mk(8, 0, 0, 0, 0, 1, 0, 0, 0, add));
    end else if (op == 7'h63) begin
      q.push_back(mk(9, 2, 0, 0, 0, 0, 0, 2, 0, alu_branch(ins)));
    end else if (op == 7'h6F) begin
      q.push_back(mk(10, 1, 0, 0, 0, 0, 0, 1, 2, add));
      q.push_back(mk(8, 0, 0, 0, 0, 1, 0, 0, 0, add));
    end else if (op == 7'h67) begin
      q.push_back(mk(11, 1, 0, 0, 0, 0, 2, 2, 1, add));
      q.push_back(mk(12, 0, 0, 0, 0, 1, 2, 1, 2, add));
    end else if (op == 7'h37) begin
      q.push_back(mk(13, 0, 0, 0, 0, 0, 0, 0, 1, int'(ALU_B)));
      q.push_back(mk(8, 0, 0, 0, 0, 1, 0, 0, 0, add));
    end else begin
      q.push_back(mk(14, 0, 0, 0, 0, 0, 0, 1, 1, add));
      q.push_back(mk(8, 0, 0, 0, 0, 1, 0, 0, 0, add));
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare(input rec_t e);
    int pcw;
    pcw = (e.pcw == 2) ? taken_m(instr, zero) : e.pcw;
    chk("state", int'(state), e.st);
    chk("pc_write", int'(pc_write), pcw);
    chk("adr_src", int'(adr_src), e.adr);
    chk("mem_write", int'(mem_write), e.mw);
    chk("ir_write", int'(ir_write), e.irw);
    chk("reg_write", int'(reg_write), e.rw);
    chk("result_src", int'(result_src), e.rs);
    chk("alu_src_a", int'(alu_src_a), e.sa);
    chk("alu_src_b", int'(alu_src_b), e.sb);
    chk("alu_control", int'(alu_control), e.alu);
    chk("illegal", int'(illegal), (e.st == 15) ? 1 : 0);
    chk("instret", int'(instret), instret_m);
  endtask

  task automatic check_reset();
    chk("rst_state", int'(state), 0);
    chk("rst_pc_write", int'(pc_write), 0);
    chk("rst_ir_write", int'(ir_write), 0);
    chk("rst_reg_write", int'(reg_write), 0);
    chk("rst_mem_write", int'(mem_write), 0);
    chk("rst_illegal", int'(illegal), 0);
    chk("rst_instret", int'(instret), instret_m);
  endtask

  // zmode: 0 random zero, 1 force 1, 2 force 0.
  // rst_at: record index at which reset is asserted (-1 none).
  // lat: required cycle count (0 = unchecked).
  task automatic run_instr(input logic [31:0] ins, input int zmode,
                           input int rst_at, input int lat,
                           input int nerr);
    rec_t e;
    int   idx;
    int   n;
    bit   err;
    build(ins, nerr);
    err = !legal_m(ins);
    idx = 0;
    n = 1;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(posedge clk);
      #1;
      if (idx == 0) instr = ins;
      zero = (zmode == 1) ? 1'b1 :
             (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (idx == rst_at) begin
        rst_n = 1'b0;
        instret_m = 0;
        #3;
        check_reset();
        return;
      end
      rst_n = 1'b1;
      #3;
      compare(e);
      if (idx > 0 && state != 4'd0) n++;
      idx++;
    end
    if (err) begin
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      instret_m = 0;
      #3;
      check_reset();
    end else begin
      instret_m++;
      if (lat > 0) chk("latency", n, lat);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [9];
    logic [31:0] ins;
    int          k, r;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    ins = $urandom;
    k = $urandom_range(0, 9);
    ins[6:0] = (k == 9) ? 7'($urandom) : ops[k];
    if (k <= 1) begin
      r = $urandom_range(0, 7);
      ins[31:25] = (r < 4) ? 7'h00 : (r < 7) ? 7'h20 : 7'($urandom);
    end
    if (k == 6 && $urandom_range(0, 3) != 0) ins[14:12] = 3'b000;
    return ins;
  endfunction

  initial begin
    chk("model_sub_alu", alu_arith(32'h40B50533, 1), int'(ALU_SUB));
    chk("model_srai_alu", alu_arith(32'h40355513, 0), int'(ALU_SHA));
    chk("model_addi_alu", alu_arith(32'h40050513, 0), int'(ALU_ADD));
    chk("model_bad_op", int'(legal_m(32'h0000007F)), 0);

    #12;
    check_reset();

    run_instr(32'h00B50533, 0, -1, 4, 0);
    chk("model_instret_add", instret_m, 1);
    run_instr(32'h40B50533, 0, -1, 4, 0);
    run_instr(32'h40355513, 0, -1, 4, 0);
    run_instr(32'h00B50463, 1, -1, 3, 0);
    run_instr(32'h00B50463, 2, -1, 3, 0);
    run_instr(32'h00B54463, 2, -1, 3, 0);
    run_instr(32'h00052503, 0, -1, 5, 0);
    run_instr(32'h00A52023, 0, -1, 4, 0);
    run_instr(32'h008000EF, 0, -1, 4, 0);
    run_instr(32'h000500E7, 0, -1, 4, 0);
    run_instr(32'h123452B7, 0, -1, 4, 0);
    run_instr(32'h00001297, 0, -1, 4, 0);
    run_instr(32'h00052503, 0, 3, 0, 0);
    run_instr(32'h00B50533, 0, -1, 4, 0);
    run_instr(32'h0000007F, 0, -1, 0, 20);

    for (int i = 0; i < 400; i++)
      run_instr(gen_instr(), 0, -1, 0, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
